// File: rtl/mem_wb_pkg.sv
// ============================================================================
// mem_wb_pkg : shared state encoding and parameter defaults for mem_wb_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_wb_pkg;

    localparam int c_data_w         = 8;
    localparam int c_reg_aw         = 3;
    localparam int c_timeout_cycles = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wb_watchdog.sv
// ============================================================================
// mem_wb_watchdog : counts busy ACCESS cycles and flags the limit being reached
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires on the busy cycle whose increment makes the count hit the limit.
    assign o_expire = i_inc && (r_count == c_cnt_w'(TIMEOUT_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/mem_wb_ctrl.sv
// ============================================================================
// mem_wb_ctrl : load/store sequencer owning the register-file write port and STALL
// Optional access watchdog enabled by defining MEM_WB_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_wb_ctrl
    import mem_wb_pkg::*;
#(
    parameter int DATA_W         = c_data_w,
    parameter int REG_AW         = c_reg_aw,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD,
    input  logic              STORE,
    input  logic              ALU_WRITE,
    input  logic [REG_AW-1:0] DEST,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic [DATA_W-1:0] STORE_DATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    output logic              RF_WRITE,
    output logic [REG_AW-1:0] RF_INADDRESS,
    output logic [DATA_W-1:0] RF_IN,
    output logic              STALL,
    output logic              ERR
);

    state_t            r_state;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [REG_AW-1:0] r_dest;
    logic              r_is_load;

    logic w_start;
    logic w_expire;
    logic w_wb_ok;

    assign w_start = (r_state == ST_IDLE) && (LOAD || STORE);

`ifdef MEM_WB_TIMEOUT_EN
    logic r_abort;
    logic r_err;
    logic w_wd_inc;

    assign w_wd_inc = (r_state == ST_ACCESS) && MEM_BUSYWAIT;

    mem_wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (CLK),
        .rst      (RESET),
        .i_clear  (w_start),
        .i_inc    (w_wd_inc),
        .o_expire (w_expire)
    );

    assign w_wb_ok = !r_abort;
    assign ERR     = r_err;
`else
    assign w_expire = 1'b0;
    assign w_wb_ok  = 1'b1;
    assign ERR      = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_dest    <= '0;
            r_is_load <= 1'b0;
`ifdef MEM_WB_TIMEOUT_EN
            r_abort   <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr    <= ALU_RESULT;
                        r_wdata   <= STORE_DATA;
                        r_dest    <= DEST;
                        r_is_load <= LOAD;
`ifdef MEM_WB_TIMEOUT_EN
                        r_abort   <= 1'b0;
`endif
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!MEM_BUSYWAIT) begin
                        if (r_is_load) begin
                            r_rdata <= MEM_READDATA;
                        end
                        r_state <= ST_FINISH;
                    end else if (w_expire) begin
                        r_state <= ST_FINISH;
`ifdef MEM_WB_TIMEOUT_EN
                        r_abort <= 1'b1;
                        r_err   <= 1'b1;
`endif
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // IDLE passes ALU writes straight through; a pending memory op stalls at once.
    always_comb begin
        RF_WRITE     = 1'b0;
        RF_IN        = ALU_RESULT;
        RF_INADDRESS = DEST;
        STALL        = 1'b0;
        MEM_READ     = 1'b0;
        MEM_WRITE    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (LOAD || STORE) begin
                    STALL = 1'b1;
                end else begin
                    RF_WRITE = ALU_WRITE;
                end
            end
            ST_ACCESS: begin
                MEM_READ  = r_is_load;
                MEM_WRITE = !r_is_load;
                STALL     = 1'b1;
            end
            ST_FINISH: begin
                RF_WRITE     = r_is_load && w_wb_ok;
                RF_IN        = r_rdata;
                RF_INADDRESS = r_dest;
            end
            default: begin
                STALL = 1'b0;
            end
        endcase
    end

    assign MEM_ADDRESS   = r_addr;
    assign MEM_WRITEDATA = r_wdata;

endmodule

`default_nettype wire
